// File: rtl/controlador_interrupciones_if.sv
// Device-bus bundle between the CPU and the interrupt controller.
// The CPU side uses the master modport and the controller uses the slave modport.
interface controlador_interrupciones_if;
  logic        enable_wishbone;
  logic        rd;
  logic        wr;
  logic [15:0] dir;
  logic [7:0]  datos_in;
  logic [7:0]  datos_out;
  logic        cpu_wait;

  modport master (
    output enable_wishbone, rd, wr, dir, datos_in,
    input  datos_out, cpu_wait
  );

  modport slave (
    input  enable_wishbone, rd, wr, dir, datos_in,
    output datos_out, cpu_wait
  );
endinterface

// File: rtl/controlador_interrupciones.sv
// Eight-source fixed-priority interrupt controller with a memory-mapped register window.
// Define CONTROLADOR_INTERRUPCIONES_SYNC_EN to add a 2-flop synchroniser on the sources.
module controlador_interrupciones #(
  parameter logic [15:0] BASE = 16'hFF00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   fuentes,
  controlador_interrupciones_if.slave  bus,
  output logic [2:0]                   interrupciones
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  mask_q, mode_q;
  logic [7:0]  datos_q, datos_d;
  logic        busy_q;
  logic [7:0]  samp, det_q, prev_q;
  logic [7:0]  eleg, rise, clr;
  logic [2:0]  id, off;
  logic [1:0]  clase;
  logic        acc, rd_acc, wr_acc, read_take, has_req, vec_ack, eoi;

`ifdef CONTROLADOR_INTERRUPCIONES_SYNC_EN
  logic [7:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= fuentes;
      sync2_q <= sync1_q;
    end
  end
  assign samp = sync2_q;
`else
  logic [7:0] samp_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) samp_q <= '0;
    else        samp_q <= fuentes;
  end
  assign samp = samp_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_q  <= '0;
      prev_q <= '0;
    end else begin
      det_q  <= samp;
      prev_q <= det_q;
    end
  end

  // A read held across two cycles is one access: the second cycle only delivers data.
  assign acc       = bus.enable_wishbone & (bus.rd | bus.wr) & (bus.dir[15:3] == BASE[15:3]);
  assign off       = bus.dir[2:0];
  assign rd_acc    = acc & bus.rd;
  assign wr_acc    = acc & bus.wr & ~bus.rd;
  assign read_take = rd_acc & ~busy_q;
  assign bus.cpu_wait  = read_take;
  assign bus.datos_out = datos_q;

  assign eleg    = pend_q & mask_q;
  assign has_req = |eleg;

  always_comb begin
    id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eleg[i]) id = 3'(i);
    end
  end

  assign clase   = (id < 3'd2) ? 2'd0 : (id < 3'd5) ? 2'd1 : 2'd2;
  assign vec_ack = read_take && (off == 3'd3) && (state_q == StReq) && has_req;
  assign eoi     = wr_acc && (off == 3'd4);
  assign rise    = det_q & ~prev_q;

  // Edge bits: set beats clear; level bits simply follow the conditioned line.
  always_comb begin
    clr = '0;
    if (wr_acc && off == 3'd0) clr = bus.datos_in;
    if (vec_ack)               clr[id] = 1'b1;
    pend_d = (mode_q & (rise | (pend_q & ~clr))) | (~mode_q & det_q);
  end

  always_comb begin
    datos_d = '0;
    if (read_take) begin
      unique case (off)
        3'd0:    datos_d = pend_q;
        3'd1:    datos_d = mask_q;
        3'd2:    datos_d = mode_q;
        3'd3:    datos_d = vec_ack ? {1'b1, 4'b0000, id} : 8'h00;
        default: datos_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      datos_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      datos_q <= datos_d;
      busy_q  <= read_take;
      if (wr_acc && off == 3'd1) mask_q <= bus.datos_in;
      if (wr_acc && off == 3'd2) mode_q <= bus.datos_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (has_req) state_d = StReq;
      StReq: begin
        if (vec_ack)       state_d = StService;
        else if (!has_req) state_d = StIdle;
      end
      StService: if (eoi) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    interrupciones = 3'b000;
    if (state_q == StReq && has_req) interrupciones[clase] = 1'b1;
  end

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Self-checking bench for controlador_interrupciones: directed scenarios plus randomized
// mask/source patterns checked against a priority model.
module tb_controlador_interrupciones;

  localparam logic [15:0] Base = 16'hFF00;
`ifdef CONTROLADOR_INTERRUPCIONES_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] fuentes = '0;
  logic [2:0] interrupciones;
  int         passed = 0;
  int         total = 0;
  logic [7:0] mdl_mask, mdl_mode;

  controlador_interrupciones_if bus ();

  controlador_interrupciones #(.BASE(Base)) dut (
    .clk            (clk),
    .reset          (reset),
    .fuentes        (fuentes),
    .bus            (bus),
    .interrupciones (interrupciones)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference rules: lowest eligible index wins, classes 0-1 / 2-4 / 5-7.
  function automatic int ref_id(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] ref_irq(input logic [7:0] v);
    int k;
    k = ref_id(v);
    if (k < 0) return 3'b000;
    return 3'b001 << ((k < 2) ? 0 : (k < 5) ? 1 : 2);
  endfunction

  function automatic logic [7:0] ref_vec(input logic [7:0] v);
    int k;
    k = ref_id(v);
    if (k < 0) return 8'h00;
    return 8'h80 | 8'(k);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
    bus.enable_wishbone = 1'b1;
    bus.wr       = 1'b1;
    bus.rd       = 1'b0;
    bus.dir      = Base + 16'(off);
    bus.datos_in = d;
    @(posedge clk);
    #1;
    bus.enable_wishbone = 1'b0;
    bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic also_wr, input logic [7:0] wd,
                          output logic [7:0] d, output logic w_t, output logic w_t1,
                          output logic [2:0] irq_t1);
    bus.enable_wishbone = 1'b1;
    bus.rd       = 1'b1;
    bus.wr       = also_wr;
    bus.dir      = a;
    bus.datos_in = wd;
    @(negedge clk);
    w_t = bus.cpu_wait;
    @(posedge clk);
    #1;
    @(negedge clk);
    w_t1   = bus.cpu_wait;
    d      = bus.datos_out;
    irq_t1 = interrupciones;
    @(posedge clk);
    #1;
    bus.enable_wishbone = 1'b0;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic w0, w1;
    logic [2:0] q;
    #2;
    total++;
    if (interrupciones !== 3'b000 || bus.datos_out !== 8'h00 || bus.cpu_wait !== 1'b0)
      $display("FAIL reset_outputs: got irq=%b dout=%h wait=%b required 000/00/0",
               interrupciones, bus.datos_out, bus.cpu_wait);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycles(1);
    bus_write(3'd2, 8'h00);
    bus_write(3'd1, 8'h01);
    fuentes = 8'h01;
    cycles(Lat + 3);
    total++;
    if (interrupciones !== 3'b001)
      $display("FAIL reset_pre_req: got %b required 001", interrupciones);
    else passed++;
    #3;
    reset = 1'b0;
    #1;
    total++;
    if (interrupciones !== 3'b000)
      $display("FAIL reset_async_irq: got %b required 000", interrupciones);
    else passed++;
    fuentes = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.cpu_wait !== 1'b0)
      $display("FAIL reset_wait: got %b required 0", bus.cpu_wait);
    else passed++;
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) begin
      bus_read(Base + 16'(r), 1'b0, 8'h00, d, w0, w1, q);
      total++;
      if (d !== 8'h00)
        $display("FAIL reset_reg%0d: got %h required 00", r, d);
      else passed++;
    end
    mdl_mask = 8'h00;
    mdl_mode = 8'h00;
  endtask

  task automatic test_edge_ack();
    logic [7:0] d;
    logic w0, w1;
    logic [2:0] q;
    bus_write(3'd2, 8'hFF);
    bus_write(3'd1, 8'h04);
    fuentes = 8'h04;
    cycles(1);
    fuentes = 8'h00;
    cycles(Lat);
    total++;
    if (interrupciones !== 3'b000)
      $display("FAIL edge_early: got %b required 000", interrupciones);
    else passed++;
    cycles(1);
    total++;
    if (interrupciones !== 3'b010)
      $display("FAIL edge_latency: got %b required 010", interrupciones);
    else passed++;
    bus_read(Base + 16'd3, 1'b0, 8'h00, d, w0, w1, q);
    total++;
    if (d !== 8'h82) $display("FAIL edge_vector: got %h required 82", d);
    else passed++;
    total++;
    if (w0 !== 1'b1 || w1 !== 1'b0)
      $display("FAIL edge_wait: got %b%b required 10", w0, w1);
    else passed++;
    total++;
    if (q !== 3'b000) $display("FAIL edge_irq_after_ack: got %b required 000", q);
    else passed++;
    bus_read(Base, 1'b0, 8'h00, d, w0, w1, q);
    total++;
    if (d !== 8'h00) $display("FAIL edge_pend_cleared: got %h required 00", d);
    else passed++;
    bus_write(3'd4, 8'h5A);
    // A fresh pulse must be presented again once EOI has returned to idle.
    fuentes = 8'h04;
    cycles(1);
    fuentes = 8'h00;
    cycles(Lat + 1);
    total++;
    if (interrupciones !== 3'b010)
      $display("FAIL edge_after_eoi: got %b required 010", interrupciones);
    else passed++;
    bus_read(Base + 16'd3, 1'b0, 8'h00, d, w0, w1, q);
    bus_write(3'd4, 8'h00);
    mdl_mode = 8'hFF;
    mdl_mask = 8'h04;
  endtask

  task automatic test_level_preempt();
    logic [7:0] d;
    logic w0, w1;
    logic [2:0] q;
    bus_write(3'd2, 8'h00);
    bus_write(3'd1, 8'hFF);
    fuentes = 8'h40;
    cycles(Lat + 2);
    total++;
    if (interrupciones !== 3'b100)
      $display("FAIL level_irq: got %b required 100", interrupciones);
    else passed++;
    fuentes = 8'h42;
    cycles(Lat + 1);
    total++;
    if (interrupciones !== 3'b001)
      $display("FAIL preempt_irq: got %b required 001", interrupciones);
    else passed++;
    bus_read(Base + 16'd3, 1'b0, 8'h00, d, w0, w1, q);
    total++;
    if (d !== 8'h81) $display("FAIL preempt_vector: got %h required 81", d);
    else passed++;
    bus_read(Base, 1'b0, 8'h00, d, w0, w1, q);
    total++;
    if (d !== 8'h42) $display("FAIL level_pend: got %h required 42", d);
    else passed++;
    fuentes = 8'h00;
    cycles(Lat + 2);
    bus_write(3'd4, 8'h00);
    cycles(1);
    mdl_mode = 8'h00;
    mdl_mask = 8'hFF;
  endtask

  task automatic test_mask_in_req();
    logic [7:0] d;
    logic w0, w1;
    logic [2:0] q;
    fuentes = 8'h10;
    cycles(Lat + 2);
    total++;
    if (interrupciones !== 3'b010)
      $display("FAIL mask_pre: got %b required 010", interrupciones);
    else passed++;
    bus_write(3'd1, 8'h00);
    total++;
    if (interrupciones !== 3'b000)
      $display("FAIL mask_irq: got %b required 000", interrupciones);
    else passed++;
    bus_read(Base + 16'd3, 1'b0, 8'h00, d, w0, w1, q);
    total++;
    if (d !== 8'h00) $display("FAIL mask_vector: got %h required 00", d);
    else passed++;
    fuentes = 8'h00;
    cycles(Lat + 2);
    mdl_mask = 8'h00;
  endtask

  task automatic test_w1c_race();
    logic [7:0] d;
    logic w0, w1;
    logic [2:0] q;
    bus_write(3'd2, 8'hFF);
    fuentes = 8'h08;
    cycles(Lat + 2);
    bus_read(Base, 1'b0, 8'h00, d, w0, w1, q);
    total++;
    if (d !== 8'h08) $display("FAIL w1c_set: got %h required 08", d);
    else passed++;
    bus_write(3'd0, 8'h08);
    bus_read(Base, 1'b0, 8'h00, d, w0, w1, q);
    total++;
    if (d !== 8'h00) $display("FAIL w1c_clear: got %h required 00", d);
    else passed++;
    fuentes = 8'h00;
    cycles(Lat + 2);
    fuentes = 8'h08;
    cycles(Lat);
    bus_write(3'd0, 8'h08);
    bus_read(Base, 1'b0, 8'h00, d, w0, w1, q);
    total++;
    if (d !== 8'h08) $display("FAIL w1c_race: got %h required 08", d);
    else passed++;
    fuentes = 8'h00;
    bus_write(3'd0, 8'hFF);
    bus_write(3'd2, 8'h00);
    cycles(Lat + 2);
    mdl_mode = 8'h00;
  endtask

  task automatic test_decode();
    logic [7:0] d;
    logic w0, w1;
    logic [2:0] q;
    bus_write(3'd1, 8'hA5);
    bus_read(Base + 16'd5, 1'b0, 8'h00, d, w0, w1, q);
    total++;
    if (d !== 8'h00 || w0 !== 1'b1)
      $display("FAIL decode_off5: got %h wait=%b required 00 wait=1", d, w0);
    else passed++;
    bus_read(Base - 16'd1, 1'b0, 8'h00, d, w0, w1, q);
    total++;
    if (d !== 8'h00 || w0 !== 1'b0)
      $display("FAIL decode_below: got %h wait=%b required 00 wait=0", d, w0);
    else passed++;
    bus_read(Base + 16'd1, 1'b1, 8'h3C, d, w0, w1, q);
    total++;
    if (d !== 8'hA5) $display("FAIL decode_rdwr_data: got %h required a5", d);
    else passed++;
    bus_read(Base + 16'd1, 1'b0, 8'h00, d, w0, w1, q);
    total++;
    if (d !== 8'hA5) $display("FAIL decode_rdwr_mask: got %h required a5", d);
    else passed++;
    bus_write(3'd1, 8'h00);
    mdl_mask = 8'h00;
  endtask

  task automatic test_random_regs();
    logic [7:0] d, v;
    logic w0, w1;
    logic [2:0] q;
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom);
      if (i[0]) begin
        bus_write(3'd2, v);
        mdl_mode = v;
      end else begin
        bus_write(3'd1, v);
        mdl_mask = v;
      end
      bus_read(Base + 16'd1, 1'b0, 8'h00, d, w0, w1, q);
      total++;
      if (d !== mdl_mask) $display("FAIL rand_mask[%0d]: got %h required %h", i, d, mdl_mask);
      else passed++;
      bus_read(Base + 16'd2, 1'b0, 8'h00, d, w0, w1, q);
      total++;
      if (d !== mdl_mode) $display("FAIL rand_mode[%0d]: got %h required %h", i, d, mdl_mode);
      else passed++;
    end
    bus_write(3'd1, 8'h00);
    bus_write(3'd2, 8'h00);
    bus_write(3'd0, 8'hFF);
    cycles(2);
    mdl_mask = 8'h00;
    mdl_mode = 8'h00;
  endtask

  task automatic test_random_prio();
    logic [7:0] d, m, p, e;
    logic w0, w1;
    logic [2:0] q;
    for (int i = 0; i < 20; i++) begin
      m = 8'($urandom);
      p = 8'($urandom_range(255, 0));
      e = m & p;
      bus_write(3'd1, m);
      fuentes = p;
      cycles(Lat + 3);
      total++;
      if (interrupciones !== ref_irq(e))
        $display("FAIL rand_irq[%0d] m=%h p=%h: got %b required %b", i, m, p,
                 interrupciones, ref_irq(e));
      else passed++;
      bus_read(Base + 16'd3, 1'b0, 8'h00, d, w0, w1, q);
      total++;
      if (d !== ref_vec(e) || q !== 3'b000)
        $display("FAIL rand_vec[%0d] m=%h p=%h: got %h irq=%b required %h irq=000", i, m, p,
                 d, q, ref_vec(e));
      else passed++;
      fuentes = 8'h00;
      cycles(Lat + 2);
      bus_write(3'd4, 8'h00);
      cycles(1);
    end
    bus_write(3'd1, 8'h00);
  endtask

  initial begin
    bus.enable_wishbone = 1'b0;
    bus.rd       = 1'b0;
    bus.wr       = 1'b0;
    bus.dir      = 16'h0000;
    bus.datos_in = 8'h00;
    test_reset();
    test_edge_ack();
    test_level_preempt();
    test_mask_in_req();
    test_w1c_race();
    test_decode();
    test_random_regs();
    test_random_prio();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
